// File: rtl/loadable_instructions_ram.sv
// Instruction memory with a run-time stream loader; core is held while loading.
// Ports: clock/reset, fetch_* (registered 1-cycle read), load_* (valid/ready loader), core_hold.
module loadable_instructions_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD =
    32'b01101100000000000000000000000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_enable,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  load_error,
  output logic                  core_hold
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_X =
    (ADDR_WIDTH+2)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH+1:0] end_addr;
  logic                  start_bad;
  logic                  start_ok;
  logic                  bad_request;
  logic                  accept;
  logic                  fetch_in_range;

  // Range is checked one bit wider so base+count cannot overflow.
  assign end_addr = {2'b00, load_base} + {1'b0, load_count};
  assign bad_request = (load_count == '0) || (end_addr > DEPTH_X);
  assign fetch_in_range = {1'b0, fetch_address} < DEPTH_W;

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    core_hold  = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          if (bad_request) begin
            start_bad = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        core_hold  = 1'b1;
        load_ready = 1'b1;
        accept     = load_valid;
        if (load_valid && remaining == 1)
          state_next = DONE;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= '0;
      remaining  <= '0;
      load_error <= 1'b0;
    end else begin
      if (start_ok) begin
        ptr        <= load_base;
        remaining  <= load_count;
        load_error <= 1'b0;
      end
      if (start_bad)
        load_error <= 1'b1;
      if (accept) begin
        ptr       <= ptr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Array has no reset; a word arriving with reset is dropped.
  always_ff @(posedge clock) begin
    if (accept && !reset)
      mem[ptr[IW-1:0]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_data  <= NOP_WORD;
      fetch_valid <= 1'b0;
    end else if (fetch_enable) begin
      if (state == LOAD || !fetch_in_range) begin
        fetch_data  <= NOP_WORD;
        fetch_valid <= 1'b0;
      end else begin
        fetch_data  <= mem[fetch_address[IW-1:0]];
        fetch_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_loadable_instructions_ram.sv
// Self-checking bench for loadable_instructions_ram.
// Directed table, corner sequences and random sessions against a word-array model.
module tb_loadable_instructions_ram;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h6C00_0000;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_enable;
  logic [AW-1:0] fetch_address;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_count;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          load_error;
  logic          core_hold;

  loadable_instructions_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fetch_enable(fetch_enable),
    .fetch_address(fetch_address),
    .fetch_data(fetch_data),
    .fetch_valid(fetch_valid),
    .load_start(load_start),
    .load_base(load_base),
    .load_count(load_count),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .load_done(load_done),
    .load_error(load_error),
    .core_hold(core_hold)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Reference model: what each written word should hold.
  logic [31:0] model_mem [DEPTH];
  int          wq [$];

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [31:0]   exp_data;
    logic          exp_valid;
  } fvec_t;

  fvec_t tbl [8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_write(input int addr, input logic [31:0] w);
    model_mem[addr] = w;
    wq.push_back(addr);
  endtask

  task automatic fetch(input int addr,
                       output logic [31:0] d,
                       output logic v);
    fetch_enable  = 1'b1;
    fetch_address = AW'(addr);
    tick();
    fetch_enable  = 1'b0;
    d = fetch_data;
    v = fetch_valid;
  endtask

  task automatic fetch_check(input string name, input int addr);
    logic [31:0] d;
    logic v;
    logic [31:0] ed;
    logic ev;
    ev = (addr < DEPTH);
    ed = ev ? model_mem[addr] : NOP;
    fetch(addr, d, v);
    check({name, "_data"}, d, ed);
    check({name, "_valid"}, 32'(v), 32'(ev));
  endtask

  // Streams words into base..; pat gives load_valid per cycle, then 1s.
  task automatic load_words(input int base,
                            input logic [31:0] words [$],
                            input bit pat [$]);
    int idx;
    int cyc;
    bit hold_ok;
    bit v;
    load_start = 1'b1;
    load_base  = AW'(base);
    load_count = (AW+1)'(words.size());
    tick();
    load_start = 1'b0;
    idx = 0;
    cyc = 0;
    hold_ok = 1'b1;
    while (idx < words.size() && cyc < 200) begin
      v = (cyc < pat.size()) ? pat[cyc] : 1'b1;
      if (!(core_hold && load_ready)) hold_ok = 1'b0;
      load_valid = v;
      load_data  = v ? words[idx] : $urandom;
      tick();
      if (v) begin
        model_write(base + idx, words[idx]);
        idx++;
      end
      cyc++;
    end
    load_valid = 1'b0;
    check("hold_during_load", 32'(hold_ok), 32'd1);
    check("words_accepted", idx, words.size());
    check("load_done_pulse", 32'(load_done), 32'd1);
    check("hold_off_in_done", 32'(core_hold), 32'd0);
    check("ready_off_in_done", 32'(load_ready), 32'd0);
    tick();
    check("load_done_cleared", 32'(load_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ws [$];
    bit np [$];
    logic [31:0] d;
    logic v;
    reset = 1'b1;
    fetch_enable = 1'b0;
    fetch_address = '0;
    load_start = 1'b0;
    load_base = '0;
    load_count = '0;
    load_valid = 1'b0;
    load_data = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state, and outputs hold until the first fetch.
    fetch_address = '0;
    tick();
    tick();
    check("rst_fetch_data", fetch_data, NOP);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);

    // Contiguous load of A,B,C at 0.
    ws = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    load_words(0, ws, np);

    tbl[0] = '{1'b1, 11'd0,    32'hAAAA_0001, 1'b1};
    tbl[1] = '{1'b1, 11'd1,    32'hBBBB_0002, 1'b1};
    tbl[2] = '{1'b0, 11'd2,    32'hBBBB_0002, 1'b1};
    tbl[3] = '{1'b1, 11'd2,    32'hCCCC_0003, 1'b1};
    tbl[4] = '{1'b1, 11'd1024, NOP,           1'b0};
    tbl[5] = '{1'b0, 11'd0,    NOP,           1'b0};
    tbl[6] = '{1'b1, 11'd2047, NOP,           1'b0};
    tbl[7] = '{1'b1, 11'd0,    32'hAAAA_0001, 1'b1};
    for (int i = 0; i < 8; i++) begin
      fetch_enable  = tbl[i].en;
      fetch_address = tbl[i].addr;
      tick();
      check($sformatf("tbl%0d_data", i), fetch_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_valid", i), 32'(fetch_valid),
            32'(tbl[i].exp_valid));
    end
    fetch_enable = 1'b0;

    // Guard word at 3, then gapped reload of 0..2.
    ws = '{32'h6666_0003};
    load_words(3, ws, np);
    ws = '{32'hDDDD_0000, 32'hEEEE_0001, 32'hFFFF_0002};
    np = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    load_words(0, ws, np);
    np = {};
    for (int a = 0; a < 4; a++)
      fetch_check($sformatf("gap_rd%0d", a), a);

    // Top-of-memory load, then out-of-range and zero-count requests.
    ws = '{32'h1020_0000, 32'h1021_0000, 32'h1022_0000, 32'h1023_0000};
    load_words(1020, ws, np);
    load_start = 1'b1;
    load_base  = 11'd1020;
    load_count = 12'd8;
    tick();
    load_start = 1'b0;
    check("err_flag", 32'(load_error), 32'd1);
    check("err_no_hold", 32'(core_hold), 32'd0);
    check("err_no_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    tick();
    load_valid = 1'b0;
    check("err_sticky", 32'(load_error), 32'd1);
    check("err_idle", 32'(core_hold), 32'd0);
    for (int a = 1020; a < 1024; a++)
      fetch_check($sformatf("err_mem%0d", a), a);
    load_start = 1'b1;
    load_base  = 11'd5;
    load_count = 12'd0;
    tick();
    load_start = 1'b0;
    check("err_zero_count", 32'(load_error), 32'd1);
    ws = '{32'h0505_0505};
    load_words(5, ws, np);
    check("err_cleared", 32'(load_error), 32'd0);

    // Fetch during LOAD is blocked; load_start in LOAD is ignored.
    load_start = 1'b1;
    load_base  = 11'd100;
    load_count = 12'd2;
    tick();
    fetch_enable  = 1'b1;
    fetch_address = 11'd0;
    load_base     = 11'd500;
    load_count    = 12'd5;
    tick();
    fetch_enable = 1'b0;
    load_start   = 1'b0;
    check("ld_fetch_valid", 32'(fetch_valid), 32'd0);
    check("ld_fetch_data", fetch_data, NOP);
    check("ld_restart_ignored", 32'(core_hold), 32'd1);
    load_valid = 1'b1;
    load_data  = 32'h0100_0100;
    tick();
    load_data  = 32'h0101_0101;
    tick();
    load_valid = 1'b0;
    check("ld_done", 32'(load_done), 32'd1);
    model_write(100, 32'h0100_0100);
    model_write(101, 32'h0101_0101);
    tick();
    fetch_check("ld_rd100", 100);
    fetch_check("ld_rd101", 101);

    // Reset after 2 of 5 words.
    ws = '{32'h0200, 32'h0201, 32'h0202, 32'h0203, 32'h0204};
    load_words(200, ws, np);
    load_start = 1'b1;
    load_base  = 11'd200;
    load_count = 12'd5;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h9200;
    tick();
    load_data  = 32'h9201;
    tick();
    load_valid = 1'b0;
    model_write(200, 32'h9200);
    model_write(201, 32'h9201);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_hold", 32'(core_hold), 32'd0);
    check("rstmid_ready", 32'(load_ready), 32'd0);
    check("rstmid_done0", 32'(load_done), 32'd0);
    tick();
    check("rstmid_done1", 32'(load_done), 32'd0);
    for (int a = 200; a < 205; a++)
      fetch_check($sformatf("rstmid_rd%0d", a), a);

    // Random sessions with random valid gaps, then random fetches.
    for (int s = 0; s < 20; s++) begin
      int cnt;
      int base;
      cnt  = $urandom_range(1, 6);
      base = $urandom_range(0, DEPTH - cnt);
      ws = {};
      np = {};
      for (int k = 0; k < cnt; k++) ws.push_back($urandom);
      for (int k = 0; k < 2 * cnt; k++)
        np.push_back(1'($urandom_range(0, 1)));
      load_words(base, ws, np);
    end
    np = {};
    for (int f = 0; f < 40; f++) begin
      int a;
      if ($urandom_range(0, 4) == 0)
        a = $urandom_range(DEPTH, 2047);
      else
        a = wq[$urandom_range(0, wq.size() - 1)];
      fetch_check($sformatf("rnd%0d_a%0d", f, a), a);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
